// File: rtl/memoria_pkg.sv
// Shared widths, FSM encoding and latency-counter helpers for the memoria ROM arbiter.
package memoria_pkg;

   localparam int unsigned ADDR_W_DEF = 11;
   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned CNT_W      = 3;
   localparam int unsigned RD_LAT_MAX = (1 << CNT_W) - 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_CAPT = 2'd2
   } state_t;

   typedef logic [CNT_W-1:0] cnt_t;

   // Latency load value, clamped into the legal 1..RD_LAT_MAX window.
   function automatic cnt_t lat_load(input int unsigned lat);
      if (lat < 1) begin
         return cnt_t'(1);
      end
      if (lat > RD_LAT_MAX) begin
         return cnt_t'(RD_LAT_MAX);
      end
      return cnt_t'(lat);
   endfunction

endpackage

// File: rtl/memoria_arb_sel.sv
// Winner selection for the two ROM requesters.
// With MEMORIA_ARB_FIXED_PRIO_EN defined, requester 0 wins every tie and rlast is ignored.
module memoria_arb_sel (
   input  logic ireq0,
   input  logic ireq1,
   input  logic rlast,
   output logic winner_c,
   output logic any_req_c
);

   assign any_req_c = ireq0 | ireq1;

`ifdef MEMORIA_ARB_FIXED_PRIO_EN
   logic unused_rlast_c;

   assign unused_rlast_c = rlast;
   assign winner_c       = ireq1 & ~ireq0;
`else
   // A tie goes to whoever was not granted last; a lone requester always wins.
   always_comb begin
      winner_c = 1'b0;
      if (ireq0 && ireq1) begin
         winner_c = ~rlast;
      end else if (ireq1) begin
         winner_c = 1'b1;
      end
   end
`endif

endmodule

// File: rtl/memoria_arb.sv
// memoria_arb: arbitrates two requesters onto one fixed-latency ROM and returns the data.
// Build option: MEMORIA_ARB_FIXED_PRIO_EN selects fixed priority (requester 0) instead of round-robin.
module memoria_arb
   import memoria_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              iclk,
   input  logic              irst_n,
   input  logic              ireq0,
   input  logic              ireq1,
   input  logic [ADDR_W-1:0] ivaddr0,
   input  logic [ADDR_W-1:0] ivaddr1,
   output logic              ogrant0,
   output logic              ogrant1,
   output logic              ovalid0,
   output logic              ovalid1,
   output logic [DATA_W-1:0] ovdata,
   output logic [ADDR_W-1:0] ovrom_addr,
   input  logic [DATA_W-1:0] ivrom_data
);

   localparam cnt_t LAT_LOAD = lat_load(RD_LAT);

   state_t state;
   cnt_t   cnt;
   logic   rlast;
   logic   winner_c;
   logic   any_req_c;

   memoria_arb_sel u_sel (
      .ireq0     (ireq0),
      .ireq1     (ireq1),
      .rlast     (rlast),
      .winner_c  (winner_c),
      .any_req_c (any_req_c)
   );

   // rlast is the last granted requester and therefore also the owner of the read in flight.
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         rlast      <= 1'b1;
         ogrant0    <= 1'b0;
         ogrant1    <= 1'b0;
         ovalid0    <= 1'b0;
         ovalid1    <= 1'b0;
         ovdata     <= '0;
         ovrom_addr <= '0;
      end else begin
         ogrant0 <= 1'b0;
         ogrant1 <= 1'b0;
         ovalid0 <= 1'b0;
         ovalid1 <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (any_req_c) begin
                  ovrom_addr <= winner_c ? ivaddr1 : ivaddr0;
                  ogrant0    <= ~winner_c;
                  ogrant1    <= winner_c;
                  rlast      <= winner_c;
                  cnt        <= LAT_LOAD;
                  state      <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // Stop at zero so a bad load can never wrap the counter.
               if (cnt <= cnt_t'(1)) begin
                  cnt   <= '0;
                  state <= ST_CAPT;
               end else begin
                  cnt <= cnt - cnt_t'(1);
               end
            end
            ST_CAPT: begin
               ovdata  <= ivrom_data;
               ovalid0 <= ~rlast;
               ovalid1 <= rlast;
               state   <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memoria_arb.sv
// Self-checking bench for memoria_arb: directed scenarios plus randomized traffic against a
// transaction-level latency model; ROM returns {addr[3:0],addr[3:0]} RD_LAT edges after the address.
module tb_memoria_arb;

   localparam int unsigned ADDR_W = 11;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned RD_LAT = 1;
`ifdef MEMORIA_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic              iclk    = 1'b0;
   logic              irst_n  = 1'b1;
   logic              ireq0   = 1'b0;
   logic              ireq1   = 1'b0;
   logic [ADDR_W-1:0] ivaddr0 = '0;
   logic [ADDR_W-1:0] ivaddr1 = '0;
   logic              ogrant0, ogrant1, ovalid0, ovalid1;
   logic [DATA_W-1:0] ovdata, ivrom_data;
   logic [ADDR_W-1:0] ovrom_addr;
   logic [DATA_W-1:0] rom_pipe [RD_LAT];

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state: edge count, earliest accepting edge, pending read.
   int                k, next_free, v_due;
   logic              mlast, v_active, v_id, eg0, eg1, ev0, ev1;
   logic [DATA_W-1:0] exp_data, v_data;
   logic [ADDR_W-1:0] exp_addr;

   memoria_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .iclk       (iclk),
      .irst_n     (irst_n),
      .ireq0      (ireq0),
      .ireq1      (ireq1),
      .ivaddr0    (ivaddr0),
      .ivaddr1    (ivaddr1),
      .ogrant0    (ogrant0),
      .ogrant1    (ogrant1),
      .ovalid0    (ovalid0),
      .ovalid1    (ovalid1),
      .ovdata     (ovdata),
      .ovrom_addr (ovrom_addr),
      .ivrom_data (ivrom_data)
   );

   always #5 iclk = ~iclk;

   function automatic logic [DATA_W-1:0] rom(input logic [ADDR_W-1:0] a);
      return {a[3:0], a[3:0]};
   endfunction

   always @(posedge iclk) begin
      rom_pipe[0] <= rom(ovrom_addr);
      for (int i = 1; i < RD_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
   end
   assign ivrom_data = rom_pipe[RD_LAT-1];

   function automatic void model_reset();
      next_free = k;
      mlast     = 1'b1;
      v_active  = 1'b0;
      exp_data  = '0;
      exp_addr  = '0;
      {eg0, eg1, ev0, ev1} = 4'b0;
   endfunction

   // One accepting edge every RD_LAT+2 edges; data due RD_LAT+1 edges after the grant edge.
   function automatic void model_step();
      logic w;
      k++;
      {eg0, eg1, ev0, ev1} = 4'b0;
      if (v_active && v_due == k) begin
         ev0 = ~v_id; ev1 = v_id; exp_data = v_data; v_active = 1'b0;
      end
      if (k >= next_free && (ireq0 || ireq1)) begin
         if (ireq0 && ireq1) w = FIXED ? 1'b0 : ~mlast;
         else w = ireq1;
         eg0 = ~w; eg1 = w; mlast = w;
         exp_addr  = w ? ivaddr1 : ivaddr0;
         v_active  = 1'b1; v_id = w; v_data = rom(exp_addr);
         v_due     = k + RD_LAT + 1;
         next_free = k + RD_LAT + 2;
      end
   endfunction

   task automatic tick();
      model_step();
      @(posedge iclk);
      @(negedge iclk);
   endtask

   task automatic do_reset();
      irst_n = 1'b0; ireq0 = 1'b0; ireq1 = 1'b0;
      @(negedge iclk);
      @(negedge iclk);
      model_reset();
      irst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1 irst_n = 1'b0;
      k = 0;
      model_reset();
      @(negedge iclk);
      n_chk++; if (ogrant0 !== 1'b0) $display("FAIL rst_grant0 got %b exp 0", ogrant0); else n_pass++;
      n_chk++; if (ogrant1 !== 1'b0) $display("FAIL rst_grant1 got %b exp 0", ogrant1); else n_pass++;
      n_chk++; if (ovalid0 !== 1'b0) $display("FAIL rst_valid0 got %b exp 0", ovalid0); else n_pass++;
      n_chk++; if (ovalid1 !== 1'b0) $display("FAIL rst_valid1 got %b exp 0", ovalid1); else n_pass++;
      n_chk++; if (ovdata !== '0) $display("FAIL rst_data got %h exp 0", ovdata); else n_pass++;
      n_chk++; if (ovrom_addr !== '0) $display("FAIL rst_addr got %h exp 0", ovrom_addr); else n_pass++;
      irst_n = 1'b1;
      tick(); tick();
      n_chk++; if ({ogrant0, ogrant1, ovalid0, ovalid1} !== 4'b0)
         $display("FAIL idle_pulses got %b exp 0000", {ogrant0, ogrant1, ovalid0, ovalid1}); else n_pass++;
   endtask

   task automatic test_single();
      int g = 0, v = 0, ng = 0, nv = 0, n1 = 0;
      logic [DATA_W-1:0] vd = '0;
      logic [ADDR_W-1:0] ga = '0;
      do_reset();
      ivaddr0 = 11'h005; ireq0 = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (ogrant0) begin ng++; if (g == 0) begin g = i; ga = ovrom_addr; end ireq0 = 1'b0; end
         if (ovalid0) begin nv++; if (v == 0) begin v = i; vd = ovdata; end end
         if (ogrant1 || ovalid1) n1++;
      end
      n_chk++; if (g != 1) $display("FAIL single_grant_lat got %0d exp 1", g); else n_pass++;
      n_chk++; if (v != RD_LAT + 2) $display("FAIL single_valid_lat got %0d exp %0d", v, RD_LAT + 2); else n_pass++;
      n_chk++; if (vd !== 8'h55) $display("FAIL single_data got %h exp 55", vd); else n_pass++;
      n_chk++; if (ga !== 11'h005) $display("FAIL single_rom_addr got %h exp 005", ga); else n_pass++;
      n_chk++; if (ng != 1 || nv != 1) $display("FAIL single_pulses got g=%0d v=%0d exp 1/1", ng, nv); else n_pass++;
      n_chk++; if (n1 != 0) $display("FAIL single_req1_quiet got %0d exp 0", n1); else n_pass++;
   endtask

   task automatic test_tie();
      int gid[$];
      logic [DATA_W-1:0] vdat[$];
      do_reset();
      ivaddr0 = 11'h003; ivaddr1 = 11'h00A; ireq0 = 1'b1; ireq1 = 1'b1;
      for (int i = 1; i <= 4 * (RD_LAT + 2); i++) begin
         tick();
         n_chk++; if ({ogrant0, ogrant1} !== {eg0, eg1})
            $display("FAIL tie_grant t=%0t got %b exp %b", $time, {ogrant0, ogrant1}, {eg0, eg1}); else n_pass++;
         n_chk++; if ({ovalid0, ovalid1} !== {ev0, ev1})
            $display("FAIL tie_valid t=%0t got %b exp %b", $time, {ovalid0, ovalid1}, {ev0, ev1}); else n_pass++;
         n_chk++; if (ovdata !== exp_data)
            $display("FAIL tie_data t=%0t got %h exp %h", $time, ovdata, exp_data); else n_pass++;
         if (ogrant0) gid.push_back(0);
         if (ogrant1) gid.push_back(1);
         if (ovalid0 || ovalid1) vdat.push_back(ovdata);
      end
      ireq0 = 1'b0; ireq1 = 1'b0;
      n_chk++; if (gid.size() != 4 || vdat.size() != 4)
         $display("FAIL tie_count got %0d/%0d exp 4/4", gid.size(), vdat.size()); else n_pass++;
      for (int i = 0; i < 4 && i < gid.size() && i < vdat.size(); i++) begin
         int eid;
         logic [DATA_W-1:0] ed;
         eid = FIXED ? 0 : i % 2;
         ed  = (eid == 0) ? 8'h33 : 8'hAA;
         n_chk++; if (gid[i] != eid) $display("FAIL tie_order[%0d] got %0d exp %0d", i, gid[i], eid); else n_pass++;
         n_chk++; if (vdat[i] !== ed) $display("FAIL tie_vdata[%0d] got %h exp %h", i, vdat[i], ed); else n_pass++;
      end
      for (int i = 0; i < RD_LAT + 3; i++) tick();
   endtask

   task automatic test_reset_mid();
      int nv = 0;
      do_reset();
      ivaddr0 = 11'h009; ireq0 = 1'b1;
      for (int i = 0; i < RD_LAT + 4; i++) begin tick(); if (ogrant0) ireq0 = 1'b0; end
      ivaddr0 = 11'h007; ireq0 = 1'b1;
      tick();
      ireq0 = 1'b0;
      #2 irst_n = 1'b0;
      #1;
      n_chk++; if ({ogrant0, ogrant1, ovalid0, ovalid1} !== 4'b0)
         $display("FAIL midrst_pulses got %b exp 0000", {ogrant0, ogrant1, ovalid0, ovalid1}); else n_pass++;
      n_chk++; if (ovdata !== '0) $display("FAIL midrst_data got %h exp 0", ovdata); else n_pass++;
      n_chk++; if (ovrom_addr !== '0) $display("FAIL midrst_addr got %h exp 0", ovrom_addr); else n_pass++;
      model_reset();
      @(negedge iclk);
      irst_n = 1'b1;
      for (int i = 0; i < RD_LAT + 5; i++) begin tick(); if (ovalid0 || ovalid1) nv++; end
      n_chk++; if (nv != 0) $display("FAIL midrst_no_valid got %0d exp 0", nv); else n_pass++;
      ivaddr0 = 11'h001; ivaddr1 = 11'h002; ireq0 = 1'b1; ireq1 = 1'b1;
      tick();
      n_chk++; if ({ogrant0, ogrant1} !== 2'b10)
         $display("FAIL midrst_first_tie got %b exp 10", {ogrant0, ogrant1}); else n_pass++;
      ireq0 = 1'b0; ireq1 = 1'b0;
      for (int i = 0; i < RD_LAT + 3; i++) tick();
   endtask

   task automatic test_late_req();
      int g1 = 0, ng1 = 0, v0 = 0, nv0 = 0, v1 = 0, nv1 = 0;
      logic [DATA_W-1:0] d1 = '0;
      do_reset();
      ivaddr0 = 11'h002; ireq0 = 1'b1;
      for (int i = 1; i <= 2 * RD_LAT + 8; i++) begin
         tick();
         if (i == 1) begin ivaddr1 = 11'h00C; ireq1 = 1'b1; end
         if (ogrant0) ireq0 = 1'b0;
         if (ogrant1) begin ng1++; if (g1 == 0) g1 = i; ireq1 = 1'b0; end
         if (ovalid0) begin nv0++; if (v0 == 0) v0 = i; end
         if (ovalid1) begin nv1++; if (v1 == 0) begin v1 = i; d1 = ovdata; end end
      end
      n_chk++; if (v0 != RD_LAT + 2 || nv0 != 1)
         $display("FAIL late_valid0 got t=%0d n=%0d exp t=%0d n=1", v0, nv0, RD_LAT + 2); else n_pass++;
      n_chk++; if (g1 != RD_LAT + 3 || ng1 != 1)
         $display("FAIL late_grant1 got t=%0d n=%0d exp t=%0d n=1", g1, ng1, RD_LAT + 3); else n_pass++;
      n_chk++; if (v1 != 2 * RD_LAT + 4 || nv1 != 1)
         $display("FAIL late_valid1 got t=%0d n=%0d exp t=%0d n=1", v1, nv1, 2 * RD_LAT + 4); else n_pass++;
      n_chk++; if (d1 !== 8'hCC) $display("FAIL late_data1 got %h exp cc", d1); else n_pass++;
   endtask

   task automatic test_sweep();
      do_reset();
      for (int a = 0; a < 16; a++) begin
         logic [ADDR_W-1:0] ad;
         logic [3:0]        nib;
         bit                seen;
         ad = ADDR_W'(a); nib = ad[3:0]; seen = 1'b0;
         ivaddr0 = ad; ireq0 = 1'b1;
         for (int i = 0; i < 4 * (RD_LAT + 2) && !seen; i++) begin
            tick();
            if (ogrant0) ireq0 = 1'b0;
            if (ovalid0) begin
               seen = 1'b1;
               n_chk++; if (ovdata !== {nib, nib})
                  $display("FAIL sweep_data t=%0t addr=%h got %h exp %h", $time, ad, ovdata, {nib, nib}); else n_pass++;
            end
         end
         if (!seen) begin
            n_chk++; $display("FAIL sweep_timeout t=%0t addr=%h got no ovalid0 exp one", $time, ad);
         end
      end
      ireq0 = 1'b0;
      tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         tick();
         n_chk++; if ({ogrant0, ogrant1} !== {eg0, eg1})
            $display("FAIL rnd_grant t=%0t got %b exp %b", $time, {ogrant0, ogrant1}, {eg0, eg1}); else n_pass++;
         n_chk++; if ({ovalid0, ovalid1} !== {ev0, ev1})
            $display("FAIL rnd_valid t=%0t got %b exp %b", $time, {ovalid0, ovalid1}, {ev0, ev1}); else n_pass++;
         n_chk++; if (ovdata !== exp_data)
            $display("FAIL rnd_data t=%0t got %h exp %h", $time, ovdata, exp_data); else n_pass++;
         n_chk++; if (ovrom_addr !== exp_addr)
            $display("FAIL rnd_rom_addr t=%0t got %h exp %h", $time, ovrom_addr, exp_addr); else n_pass++;
         if (ireq0 && eg0) ireq0 = 1'b0;
         else if (!ireq0 && $urandom_range(0, 2) == 0) begin ivaddr0 = ADDR_W'($urandom); ireq0 = 1'b1; end
         if (ireq1 && eg1) ireq1 = 1'b0;
         else if (!ireq1 && $urandom_range(0, 2) == 0) begin ivaddr1 = ADDR_W'($urandom); ireq1 = 1'b1; end
      end
      ireq0 = 1'b0; ireq1 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_reset_mid();
      test_late_req();
      test_sweep();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
